// File: rtl/cpu_pkg.sv
// Shared encodings for the core's execute-stage blocks.
// Covers multiply/divide opcodes and the mult/div sequencer states.
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Bit 1 selects divide; bit 0 clear means a signed operation.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Final sign correction of the unsigned multiply/divide results into hi/lo.
// A zero divisor forces lo to all ones; the remainder then equals the dividend.
module md_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic                  sign_a,
    input  logic                  sign_b,
    input  logic                  div_zero,
    input  logic [2*DATA_W-1:0]   product,
    input  logic [DATA_W-1:0]     quotient,
    input  logic [DATA_W-1:0]     remainder,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Remainder follows the dividend sign, so truncating division falls out.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -product : product;
        quot_fix = (sign_a ^ sign_b) ? -quotient : quotient;
        rem_fix  = sign_a ? -remainder : remainder;
        if (is_div) begin
            hi = rem_fix;
            lo = div_zero ? '1 : quot_fix;
        end else begin
            hi = prod_fix[2*DATA_W-1:DATA_W];
            lo = prod_fix[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing the HI/LO pair.
// One shift-add or restoring shift-subtract step per enabled cycle, then a sign-fix cycle.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    md_state_e            state, state_next;
    md_op_e               op_reg;
    logic                 sign_a_reg, sign_b_reg, div_zero_reg;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    opnd_reg;
    logic [2*DATA_W-1:0]  acc;
    logic [DATA_W:0]      rem;

    logic                 accept, last_iter, in_signed, in_div;
    logic [DATA_W-1:0]    mag_a, mag_b;
    logic [DATA_W:0]      mul_sum;
    logic [DATA_W+1:0]    div_shift, div_diff;
    logic [DATA_W-1:0]    fix_hi, fix_lo;

    assign busy      = (state != MD_IDLE);
    assign accept    = (state == MD_IDLE) && start && !flush;
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));
    assign in_signed = md_is_signed(op);
    assign in_div    = md_is_div(op);
    assign mag_a     = (in_signed && operand_a[DATA_W-1]) ? -operand_a : operand_a;
    assign mag_b     = (in_signed && operand_b[DATA_W-1]) ? -operand_b : operand_b;

    // opnd_reg holds the multiplicand or the divisor; acc low half holds multiplier or quotient.
    assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd_reg} : '0);
    assign div_shift = {rem, acc[DATA_W-1]};
    assign div_diff  = div_shift - {2'b00, opnd_reg};

    always_ff @(posedge clk) begin
        if (!arst_n)
            state <= MD_IDLE;
        else if (enable)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = MD_CALC;
            MD_CALC: begin
                if (flush)
                    state_next = MD_IDLE;
                else if (last_iter)
                    state_next = MD_FIX;
            end
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // A flushed CALC/FIX cycle leaves every register as it was; the state register returns to IDLE.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            op_reg       <= MD_MULT;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            cnt          <= '0;
            opnd_reg     <= '0;
            acc          <= '0;
            rem          <= '0;
            done         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            div_by_zero  <= 1'b0;
        end else if (!enable) begin
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op_reg       <= md_op_e'(op);
                        sign_a_reg   <= in_signed && operand_a[DATA_W-1];
                        sign_b_reg   <= in_signed && operand_b[DATA_W-1];
                        div_zero_reg <= in_div && (operand_b == '0);
                        opnd_reg     <= in_div ? mag_b : mag_a;
                        acc          <= {{DATA_W{1'b0}}, (in_div ? mag_a : mag_b)};
                        rem          <= '0;
                        cnt          <= '0;
                        div_by_zero  <= 1'b0;
                    end
                end
                MD_CALC: begin
                    if (!flush) begin
                        cnt <= cnt + 1'b1;
                        if (md_is_div(op_reg)) begin
                            acc <= {acc[2*DATA_W-1:DATA_W], acc[DATA_W-2:0], ~div_diff[DATA_W+1]};
                            rem <= div_diff[DATA_W+1] ? div_shift[DATA_W:0] : div_diff[DATA_W:0];
                        end else begin
                            acc <= {mul_sum, acc[DATA_W-1:1]};
                        end
                    end
                end
                MD_FIX: begin
                    if (!flush) begin
                        hi          <= fix_hi;
                        lo          <= fix_lo;
                        div_by_zero <= div_zero_reg;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    md_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .is_div    (md_is_div(op_reg)),
        .sign_a    (sign_a_reg),
        .sign_b    (sign_b_reg),
        .div_zero  (div_zero_reg),
        .product   (acc),
        .quotient  (acc[DATA_W-1:0]),
        .remainder (rem[DATA_W-1:0]),
        .hi        (fix_hi),
        .lo        (fix_lo)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences
// and randomized operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import cpu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         arst_n, enable, start, flush;
    logic [1:0]   op;
    logic [W-1:0] operand_a, operand_b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[7];

    mult_div_unit #(.DATA_W(W)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference results straight from the arithmetic definition of each opcode.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] mhi, output logic [W-1:0] mlo, output logic mdbz);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        mdbz = 1'b0;
        sa   = a;
        sb   = b;
        mhi  = '0;
        mlo  = '0;
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                {mhi, mlo} = sp;
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                {mhi, mlo} = up;
            end
            default: begin
                if (b == 0) begin
                    mlo  = '1;
                    mhi  = a;
                    mdbz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mlo = 32'h8000_0000;
                        mhi = 32'h0;
                    end else begin
                        mlo = sa / sb;
                        mhi = sa % sb;
                    end
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
    endtask

    // Issues an op and counts edges after acceptance until done (bounded to 200).
    task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall_at, input int stall_len, input int extra_at,
                         output int lat, output int busy_cycles);
        applyStimulus(o, a, b);
        @(posedge clk); #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cycles++;
            if (lat == stall_at) enable = 1'b0;
            if (lat == stall_at + stall_len) enable = 1'b1;
            if (lat == extra_at) applyStimulus(~o, ~a, b + 1);
            if (lat == extra_at + 1) start = 1'b0;
        end
        enable = 1'b1;
        start  = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
        logic [W-1:0] ehi, elo;
        logic         edbz;
        model(o, a, b, ehi, elo, edbz);
        checkOutput({name, " hi"}, hi, ehi);
        checkOutput({name, " lo"}, lo, elo);
        checkOutput({name, " dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        int           lat, bc, cyc;
        logic         saw_done;
        logic [W-1:0] prev_hi, prev_lo;
        logic         prev_dbz;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[5] = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};

        arst_n = 1'b0; enable = 1'b1; start = 1'b0; flush = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset hi", hi, 0);
        checkOutput("reset lo", lo, 0);
        checkOutput("reset dbz", div_by_zero, 0);
        @(negedge clk);
        arst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, -1, 0, -1, lat, bc);
            checkOutput($sformatf("vec%0d latency", i), lat, 33);
            checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            checkOutput($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].dbz);
            if (i == 0) begin
                checkOutput("vec0 busy cycles", bc, 33);
                @(posedge clk); #1;
                checkOutput("vec0 done one cycle", done, 0);
            end
        end

        $display("[TB] divide-by-zero flag cleared by next start");
        @(negedge clk);
        runOp(2'b11, 32'd55, 32'd0, -1, 0, -1, lat, bc);
        checkOutput("dbz set", div_by_zero, 1);
        @(negedge clk);
        applyStimulus(2'b01, 32'd3, 32'd5);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("dbz cleared at accept", div_by_zero, 0);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("dbz clear op lo", lo, 15);

        $display("[TB] stall of 5 cycles mid-op");
        @(negedge clk);
        runOp(2'b00, 32'd12345, -32'sd6789, 10, 5, -1, lat, bc);
        checkOutput("stall latency", lat, 38);
        checkResult("stall", 2'b00, 32'd12345, -32'sd6789);

        $display("[TB] start while busy is ignored");
        @(negedge clk);
        runOp(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, -1, 0, 5, lat, bc);
        checkOutput("busy-start latency", lat, 33);
        checkResult("busy-start", 2'b11, 32'hDEAD_BEEF, 32'h0000_1234);
        @(posedge clk); #1;
        checkOutput("busy-start no requeue", busy, 0);

        $display("[TB] back-to-back start in done cycle");
        @(negedge clk);
        runOp(2'b00, 32'h0001_2345, 32'h0000_0F0F, -1, 0, -1, lat, bc);
        checkResult("b2b first", 2'b00, 32'h0001_2345, 32'h0000_0F0F);
        runOp(2'b10, -32'sd1000001, 32'd37, -1, 0, -1, lat, bc);
        checkOutput("b2b second latency", lat, 33);
        checkResult("b2b second", 2'b10, -32'sd1000001, 32'd37);

        $display("[TB] flush mid-divide");
        prev_hi  = hi;
        prev_lo  = lo;
        prev_dbz = div_by_zero;
        @(negedge clk);
        applyStimulus(2'b11, 32'd1000, 32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush busy", busy, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("flush no done", saw_done, 0);
        checkOutput("flush hi kept", hi, prev_hi);
        checkOutput("flush lo kept", lo, prev_lo);
        checkOutput("flush dbz kept", div_by_zero, prev_dbz);

        $display("[TB] flush with start in idle");
        @(negedge clk);
        applyStimulus(2'b01, 32'd9, 32'd9);
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush-start busy", busy, 0);

        $display("[TB] reset mid-op");
        @(negedge clk);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset hi", hi, 0);
        checkOutput("midreset lo", lo, 0);
        checkOutput("midreset dbz", div_by_zero, 0);
        @(negedge clk);
        arst_n = 1'b1;

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            @(negedge clk);
            runOp(ro, ra, rb, -1, 0, -1, lat, bc);
            checkOutput($sformatf("rand%0d latency", i), lat, 33);
            checkResult($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
